// File: rtl/pe_digit_display.sv
// pe_digit_display: memory-mapped 8-digit hex driver for a common-anode,
// time-multiplexed 7-segment display with digit mask and register read-back.
module pe_digit_display #(
  parameter logic [11:0] ADDR_DATA = 12'h000,
  parameter logic [11:0] ADDR_MASK = 12'h004,
  parameter int unsigned SCAN_DIV  = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  dig_en,
  output logic [7:0]  seg
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [31:0]   data_q, data_d;
  logic [7:0]    mask_q, mask_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    dig_en_q, dig_en_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    nib;
  logic          wrap;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    hex7 = 8'hFF;
    unique case (v)
      4'h0: hex7 = 8'hC0;
      4'h1: hex7 = 8'hF9;
      4'h2: hex7 = 8'hA4;
      4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h92;
      4'h6: hex7 = 8'h82;
      4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;
      4'h9: hex7 = 8'h90;
      4'hA: hex7 = 8'h88;
      4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;
      4'hD: hex7 = 8'hA1;
      4'hE: hex7 = 8'h86;
      4'hF: hex7 = 8'h8E;
    endcase
  endfunction

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (we && addr == ADDR_DATA) data_d = wdata;
    if (we && addr == ADDR_MASK) mask_d = wdata[7:0];
  end

  assign wrap  = (cnt_q == CNT_MAX);
  assign cnt_d = wrap ? '0 : cnt_q + CW'(1);
  assign idx_d = wrap ? idx_q + 3'd1 : idx_q;
  assign nib   = data_q[{idx_q, 2'b00} +: 4];

  // Pins are always derived from the live registers, so writes show up
  // on the very next cycle instead of waiting for the next scan slot.
  always_comb begin
    dig_en_d = 8'hFF;
    seg_d    = 8'hFF;
    if (mask_q[idx_q]) begin
      dig_en_d = ~(8'h01 << idx_q);
      seg_d    = hex7(nib);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= 32'h0;
      mask_q   <= 8'hFF;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      dig_en_q <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dig_en_q <= dig_en_d;
      seg_q    <= seg_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (addr == ADDR_DATA)      rdata = data_q;
    else if (addr == ADDR_MASK) rdata = {24'h0, mask_q};
  end

  assign dig_en = dig_en_q;
  assign seg    = seg_q;

endmodule

// File: tb/tb_pe_digit_display.sv
// tb_pe_digit_display: directed stimulus with a tick-count based display
// model checked every cycle, plus literal pins for each scenario.
module tb_pe_digit_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  dig_en;
  logic [7:0]  seg;

  int passed = 0;
  int total  = 0;
  int n      = 0;

  logic [7:0] hexs [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                            8'h82, 8'hF8, 8'h80, 8'h90, 8'h88, 8'h83,
                            8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] en_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7,
                             8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [7:0] sg_tab [8] = '{8'h8E, 8'h86, 8'hA1, 8'hC6,
                             8'h83, 8'h88, 8'h90, 8'h80};

  logic [31:0] m_data;
  logic [7:0]  m_mask;
  int          ticks;
  logic [7:0]  exp_en, exp_seg;

  pe_digit_display #(
    .ADDR_DATA(12'h000),
    .ADDR_MASK(12'h004),
    .SCAN_DIV (SD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .dig_en(dig_en),
    .seg   (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Digit index comes straight from elapsed ticks since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data  = 32'h0;
      m_mask  = 8'hFF;
      ticks   = 0;
      exp_en  = 8'hFF;
      exp_seg = 8'hFF;
    end else begin
      int i;
      i = (ticks / SD) % 8;
      if (m_mask[i]) begin
        exp_en  = ~(8'h01 << i);
        exp_seg = hexs[(m_data >> (4 * i)) & 32'hF];
      end else begin
        exp_en  = 8'hFF;
        exp_seg = 8'hFF;
      end
      ticks++;
      if (we && addr == 12'h000) m_data = wdata;
      if (we && addr == 12'h004) m_mask = wdata[7:0];
    end
  end

  always @(negedge clk) begin
    check("model_dig_en", {24'h0, dig_en}, {24'h0, exp_en});
    check("model_seg", {24'h0, seg}, {24'h0, exp_seg});
    check("one_digit_low", 32'($countones(~dig_en) <= 1), 32'd1);
  end

  task automatic cyc();
    @(negedge clk);
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) cyc();
  endtask

  initial begin
    rst   = 1'b0;
    addr  = 12'h000;
    we    = 1'b0;
    wdata = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_dig_en", {24'h0, dig_en}, 32'hFF);
    check("rst_seg", {24'h0, seg}, 32'hFF);
    #1 check("rst_rdata_data", rdata, 32'h0);
    addr = 12'h004;
    #1 check("rst_rdata_mask", rdata, 32'hFF);

    rst   = 1'b1;
    addr  = 12'h000;
    we    = 1'b1;
    wdata = 32'h89ABCDEF;
    n     = 0;
    cyc();
    we = 1'b0;
    check("first_lit_en", {24'h0, dig_en}, 32'hFE);
    check("first_lit_seg", {24'h0, seg}, 32'hC0);
    #1 check("rdata_after_wr", rdata, 32'h89ABCDEF);

    while (n < 40) begin
      cyc();
      if (n % 4 == 0) begin
        check("scan_en", {24'h0, dig_en}, {24'h0, en_tab[((n - 1) / 4) % 8]});
        check("scan_seg", {24'h0, seg}, {24'h0, sg_tab[((n - 1) / 4) % 8]});
      end
    end

    addr  = 12'h004;
    we    = 1'b1;
    wdata = 32'h0000000F;
    #1 check("mask_old_rdata", rdata, 32'hFF);
    cyc();
    we = 1'b0;
    #1 check("mask_rdata", rdata, 32'h0000000F);
    run_to(52);
    check("mask_d4_en", {24'h0, dig_en}, 32'hFF);
    check("mask_d4_seg", {24'h0, seg}, 32'hFF);
    run_to(68);
    check("mask_d0_en", {24'h0, dig_en}, 32'hFE);
    check("mask_d0_seg", {24'h0, seg}, 32'h8E);

    run_to(72);
    addr  = 12'h070;
    we    = 1'b1;
    wdata = 32'h12345678;
    #1 check("bad_addr_rdata", rdata, 32'h0);
    cyc();
    addr = 12'h000;
    we   = 1'b0;
    cyc();
    #1 check("ignored_wr_data", rdata, 32'h89ABCDEF);

    addr  = 12'h004;
    we    = 1'b1;
    wdata = 32'h000000FF;
    cyc();
    we   = 1'b0;
    addr = 12'h000;

    run_to(97);
    check("pre_wr_en", {24'h0, dig_en}, 32'hFE);
    check("pre_wr_seg", {24'h0, seg}, 32'h8E);
    we    = 1'b1;
    wdata = 32'h00000001;
    cyc();
    we = 1'b0;
    check("wr_edge_seg", {24'h0, seg}, 32'h8E);
    cyc();
    check("mid_wr_seg", {24'h0, seg}, 32'hF9);
    check("mid_wr_en", {24'h0, dig_en}, 32'hFE);
    cyc();
    check("slot_end_en", {24'h0, dig_en}, 32'hFE);
    check("slot_end_seg", {24'h0, seg}, 32'hF9);

    run_to(118);
    check("d5_en", {24'h0, dig_en}, 32'hDF);
    check("d5_seg", {24'h0, seg}, 32'hC0);
    #2 rst = 1'b0;
    #1 check("async_en", {24'h0, dig_en}, 32'hFF);
    check("async_seg", {24'h0, seg}, 32'hFF);
    @(negedge clk);
    rst = 1'b1;
    n   = 0;
    cyc();
    check("restart_en", {24'h0, dig_en}, 32'hFE);
    check("restart_seg", {24'h0, seg}, 32'hC0);
    #1 check("restart_data", rdata, 32'h0);
    addr = 12'h004;
    #1 check("restart_mask", rdata, 32'hFF);
    run_to(12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
